// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Sits on the FFT output stream ahead of the mel filterbank. It counts the
// complex bins of each frame and forwards only bins 0..N_BINS-1. Each
// forwarded bin carries its bin index, its frame index and start/end-of-frame
// flags. A run begins with a start pulse and ends after N_FRAMES frames,
// when done is raised. Upstream cannot be stalled, so a bin that arrives
// outside a run is dropped and the sticky err_drop flag is set.
module fft_frame_sequencer #(
  parameter  int I_BW     = 14,
  parameter  int N_FFT    = 512,
  parameter  int N_BINS   = 257,
  parameter  int N_FRAMES = 178,
  localparam int BIN_W    = (N_FFT > 1) ? $clog2(N_FFT) : 1,
  localparam int FRM_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             di_en,
  input  logic [I_BW-1:0]  di_re,
  input  logic [I_BW-1:0]  di_im,
  output logic             do_en,
  output logic [I_BW-1:0]  do_re,
  output logic [I_BW-1:0]  do_im,
  output logic [BIN_W-1:0] do_bin,
  output logic [FRM_W-1:0] do_frame,
  output logic             do_sof,
  output logic             do_eof,
  output logic             busy,
  output logic             done,
  output logic             err_drop
);

  // Compare constants sized to the counters they are compared against.
  // BIN_KEEP has one extra bit so that N_BINS == N_FFT still fits.
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(N_FFT - 1);
  localparam logic [BIN_W-1:0] BIN_EOF  = BIN_W'(N_BINS - 1);
  localparam logic [BIN_W:0]   BIN_KEEP = (BIN_W + 1)'(N_BINS);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(N_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_cnt;
  logic [FRM_W-1:0] frm_cnt;

  // Decode the current bin position. These signals are only used in RUN.
  logic bin_keep;
  logic bin_first;
  logic bin_eof;
  logic bin_last;
  logic frm_last;

  assign bin_keep  = ({1'b0, bin_cnt} < BIN_KEEP);
  assign bin_first = (bin_cnt == '0);
  assign bin_eof   = (bin_cnt == BIN_EOF);
  assign bin_last  = (bin_cnt == BIN_LAST);
  assign frm_last  = (frm_cnt == FRM_LAST);

  // Run-control FSM. It also owns the bin/frame counters and every output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data outputs are reset as well, because every output must read 0 after rst.
      state    <= S_IDLE;
      bin_cnt  <= '0;
      frm_cnt  <= '0;
      do_en    <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
      do_bin   <= '0;
      do_frame <= '0;
      do_sof   <= 1'b0;
      do_eof   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge counters.
      // The strobes are single-cycle. Data and tags hold until the next forwarded bin.
      do_en  <= 1'b0;
      do_sof <= 1'b0;
      do_eof <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // A di_en that arrives together with start is dropped silently.
            state    <= S_RUN;
            bin_cnt  <= '0;
            frm_cnt  <= '0;
            done     <= 1'b0;
            err_drop <= 1'b0;
            busy     <= 1'b1;
          end else if (di_en) begin
            err_drop <= 1'b1;
          end
        end

        S_RUN: begin
          // start is ignored here. Only di_en moves the run forward.
          if (di_en) begin
            if (bin_keep) begin
              do_en    <= 1'b1;
              do_re    <= di_re;
              do_im    <= di_im;
              do_bin   <= bin_cnt;
              do_frame <= frm_cnt;
              do_sof   <= bin_first;
              do_eof   <= bin_eof;
            end

            if (bin_last) begin
              bin_cnt <= '0;
              if (frm_last) begin
                // Last beat of the run. The counters park at zero and never wrap past the end.
                frm_cnt <= '0;
                state   <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                frm_cnt <= frm_cnt + FRM_W'(1);
              end
            end else begin
              bin_cnt <= bin_cnt + BIN_W'(1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
